input_mat_load_ctrl: RTL and testbench
======================================

# input_mat_load_ctrl

Sequencer that fills the 8x8 input-matrix register bank from on-chip RAM before a systolic pass. Each RAM read returns 4 matrix elements, so a full matrix takes 16 reads. The block generates the RAM read address and strobe, the bank's `enable`, `bank_select_line` and `select_line`, and a start/busy/done handshake toward the top-level controller. It sits between the top controller, the input RAM read port and the input-matrix register bank. The bank's internal 3-stage select delay absorbs RAM read latency.

## Interface
- `ADDR_WIDTH`, default 8: RAM address width.
- `SELECT`, default 3: width of the bank and row select lines.
- `NUM_READS`, default 16: reads per matrix (8 rows x 2 halves).
- `DRAIN_CYCLES`, default 3: cycles `enable` stays high after the last read, to flush the bank's delay pipe.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to load a matrix; honoured only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first RAM address of the matrix; latched on an accepted `start`.
- `hold`  in  1  stall; freezes all progress while high.
- `ram_rd_en`  out  1  RAM read strobe.
- `ram_addr`  out  ADDR_WIDTH  RAM read address.
- `enable`  out  1  drives the bank `enable`.
- `bank_select_line`  out  SELECT  row (bank) index, 0..7.
- `select_line`  out  SELECT  half-row index inside a bank, written as {2'b00, half}.
- `busy`  out  1  high from LOAD through DRAIN.
- `done`  out  1  one-cycle pulse when the matrix is loaded.

## Operation
- **States:** IDLE, LOAD, DRAIN, DONE.
- **IDLE -> LOAD:**
  - On `start` = 1.
  - Latch `base_addr`.
  - Clear read counter `k` (4 bits).
- **In LOAD (when `hold` = 0):**
  - `ram_rd_en` = 1, `enable` = 1.
  - `ram_addr` = base + k, modulo 2^ADDR_WIDTH (wraps silently).
  - `bank_select_line` = k[3:1].
  - `select_line` = {2'b00, k[0]}.
  - k increments each cycle.
  - When k = NUM_READS-1 and not held, go to DRAIN.
- **In DRAIN (when `hold` = 0):**
  - `ram_rd_en` = 0, `enable` = 1.
  - `bank_select_line`, `select_line` and `ram_addr` hold their last LOAD values (7, 1, base+15).
  - Drain counter counts DRAIN_CYCLES cycles, then go to DONE.
- **DONE:**
  - `done` = 1, `busy` = 0, `enable` = 0.
  - Next cycle returns to IDLE unconditionally.
- **`hold` = 1 in LOAD or DRAIN:**
  - `ram_rd_en` = 0, `enable` = 0.
  - Counters and select outputs frozen.
  - Resumes exactly where it stopped.
  - `enable` low also freezes the bank's delay pipe, so alignment is preserved.
- **`hold` in IDLE or DONE:** no effect.
- **`start` while `busy` or in DONE:** ignored. No queueing.
- **Select outputs in IDLE:** keep last values. `ram_rd_en` = `enable` = 0.

## Timing
- **Reset values:** every output 0. State IDLE, counters 0.
- **Unheld load, with `start` sampled high at cycle 0:**
  - LOAD covers cycles 1..16; addresses base..base+15 are presented on those cycles.
  - DRAIN covers cycles 17..19.
  - `done` = 1 at cycle 20.
  - `busy` = 1 on cycles 1..19.
- **Latency:** start to done = 20 cycles + number of held cycles.
- **Output timing:** all outputs are registered (glitch-free), so a `hold` sampled at cycle n affects outputs at cycle n+1.
- **Reset mid-operation:** next cycle is IDLE with all outputs 0. No `done` pulse; a partial matrix is left in the bank.
- **`start` and `reset` in the same cycle:** `reset` wins.

## Test plan
- **Basic load:** `base_addr` = 0x20, `start` at cycle 0, `hold` = 0.
  - Addresses 0x20..0x2F on cycles 1..16.
  - (`bank_select_line`, `select_line`) goes (0,0),(0,1),(1,0) … (7,1).
  - `enable` high on cycles 1..19; `done` only at cycle 20.
- **Address wrap:** `base_addr` = 0xF8 -> addresses 0xF8..0xFF, then 0x00..0x07.
- **Hold mid-load:** `hold` high on cycles 5..7.
  - Cycles 6..8: `ram_addr` frozen at base+4, `ram_rd_en` = `enable` = 0.
  - Load resumes with base+5; `done` at cycle 23.
- **Hold in DRAIN:** `hold` high for 2 cycles starting at cycle 18 -> `done` moves to cycle 22 and selects remain (7,1).
- **Ignored start:** `start` pulses at cycles 5 and 20 -> no change to sequence or latched base; `done` stays a single pulse at cycle 20.
- **Reset mid-operation:** `reset` at cycle 10 -> cycle 11 all outputs 0, state IDLE. A new `start` at cycle 12 loads normally with `done` at cycle 32.

Source files
------------

// File: rtl/input_mat_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// input_mat_load_ctrl_if
//   Bundles the handshake toward the top controller, the input-RAM read port
//   and the input-matrix bank controls driven by input_mat_load_ctrl.
//
//   Signals:
//     start            controller -> loader, one-cycle load request
//     base_addr        controller -> loader, first RAM address of the matrix
//     hold             controller -> loader, stall request
//     ram_rd_en        loader -> RAM, read strobe
//     ram_addr         loader -> RAM, read address
//     enable           loader -> bank, shift/write enable
//     bank_select_line loader -> bank, row index 0..7
//     select_line      loader -> bank, half-row index {2'b00, half}
//     busy             loader -> controller, load in progress
//     done             loader -> controller, one-cycle completion pulse
//
//   Modports:
//     master  the controller side (drives start/base_addr/hold)
//     slave   the loader itself
// ---------------------------------------------------------------------------
interface input_mat_load_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int SELECT     = 3
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  hold;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  enable;
  logic [SELECT-1:0]     bank_select_line;
  logic [SELECT-1:0]     select_line;
  logic                  busy;
  logic                  done;

  modport master (
    output start,
    output base_addr,
    output hold,
    input  ram_rd_en,
    input  ram_addr,
    input  enable,
    input  bank_select_line,
    input  select_line,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  base_addr,
    input  hold,
    output ram_rd_en,
    output ram_addr,
    output enable,
    output bank_select_line,
    output select_line,
    output busy,
    output done
  );

endinterface

// File: rtl/input_mat_load_ctrl.sv
// ---------------------------------------------------------------------------
// input_mat_load_ctrl
//   Fills the 8x8 input-matrix register bank from on-chip RAM ahead of a
//   systolic pass. Each RAM word carries 4 elements, so a matrix is NUM_READS
//   reads (8 rows x 2 halves). After the last read, enable stays high for
//   DRAIN_CYCLES more cycles so the bank's internal select delay pipe, which
//   absorbs RAM read latency, can flush the final words into place.
//
//   Ports:
//     clk    single rising-edge clock
//     reset  synchronous, active-high reset
//     bus    input_mat_load_ctrl_if.slave
//              start/base_addr/hold in, ram_rd_en/ram_addr/enable/
//              bank_select_line/select_line/busy/done out
//
//   All outputs are registered; an input sampled on edge n shows up on the
//   outputs in the cycle following that edge.
// ---------------------------------------------------------------------------
module input_mat_load_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int SELECT       = 3,
  parameter int NUM_READS    = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input logic                 clk,
  input logic                 reset,
  input_mat_load_ctrl_if.slave bus
);

  localparam int KW = (NUM_READS > 1) ? $clog2(NUM_READS) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [KW-1:0]         k_q;
  logic [DW-1:0]         drain_q;

  logic                  ramRdEn_q;
  logic [ADDR_WIDTH-1:0] ramAddr_q;
  logic                  enable_q;
  logic [SELECT-1:0]     bankSel_q;
  logic [SELECT-1:0]     halfSel_q;
  logic                  busy_q;
  logic                  done_q;

  // Index of the read that will be presented next; k_q always names the read
  // currently on the outputs, so a hold simply leaves k_q alone.
  logic [KW-1:0] k_d;
  assign k_d = k_q + KW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      k_q       <= '0;
      drain_q   <= '0;
      ramRdEn_q <= 1'b0;
      ramAddr_q <= '0;
      enable_q  <= 1'b0;
      bankSel_q <= '0;
      halfSel_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ramRdEn_q <= 1'b0;
          enable_q  <= 1'b0;
          done_q    <= 1'b0;
          if (bus.start) begin
            // The first read goes out in the very next cycle, so its address
            // comes straight from the port rather than from base_q.
            state_q   <= LOAD;
            base_q    <= bus.base_addr;
            k_q       <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b1;
            ramRdEn_q <= 1'b1;
            enable_q  <= 1'b1;
            ramAddr_q <= bus.base_addr;
            bankSel_q <= '0;
            halfSel_q <= '0;
          end
        end

        LOAD: begin
          if (bus.hold) begin
            ramRdEn_q <= 1'b0;
            enable_q  <= 1'b0;
          end else if (k_q == KW'(NUM_READS - 1)) begin
            // Address and selects keep the last read's values during drain.
            state_q   <= DRAIN;
            ramRdEn_q <= 1'b0;
            enable_q  <= 1'b1;
          end else begin
            k_q       <= k_d;
            ramRdEn_q <= 1'b1;
            enable_q  <= 1'b1;
            ramAddr_q <= base_q + ADDR_WIDTH'(k_d);
            bankSel_q <= SELECT'(k_d >> 1);
            halfSel_q <= SELECT'(k_d[0]);
          end
        end

        DRAIN: begin
          if (bus.hold) begin
            enable_q <= 1'b0;
          end else if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
            state_q  <= DONE;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            drain_q  <= drain_q + DW'(1);
            enable_q <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ram_rd_en        = ramRdEn_q;
  assign bus.ram_addr         = ramAddr_q;
  assign bus.enable           = enable_q;
  assign bus.bank_select_line = bankSel_q;
  assign bus.select_line      = halfSel_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_input_mat_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_input_mat_load_ctrl
//   Self-checking bench for input_mat_load_ctrl. A reference model describes
//   a matrix load as a queue of work items (16 reads followed by 3 drain
//   slots); each unheld cycle consumes one item, and an empty queue means the
//   load is complete. Directed scenarios reproduce the documented timelines,
//   then randomized start/hold/reset traffic runs against the same model.
// ---------------------------------------------------------------------------
module tb_input_mat_load_ctrl;

  localparam int AW = 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  input_mat_load_ctrl_if #(.ADDR_WIDTH(AW), .SELECT(SW)) bus ();

  input_mat_load_ctrl #(
    .ADDR_WIDTH  (AW),
    .SELECT      (SW),
    .NUM_READS   (16),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: 0 idle, 1 loading/draining, 2 done.
  int          phase;
  int          work[$];
  logic [7:0]  mBase;
  logic        expRd, expEn, expBusy, expDone;
  logic [7:0]  expAddr;
  logic [2:0]  expBank, expSel;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("ram_rd_en", 32'(bus.ram_rd_en), 32'(expRd));
    checkOutput("ram_addr", 32'(bus.ram_addr), 32'(expAddr));
    checkOutput("enable", 32'(bus.enable), 32'(expEn));
    checkOutput("bank_select_line", 32'(bus.bank_select_line), 32'(expBank));
    checkOutput("select_line", 32'(bus.select_line), 32'(expSel));
    checkOutput("busy", 32'(bus.busy), 32'(expBusy));
    checkOutput("done", 32'(bus.done), 32'(expDone));
  endtask

  // Take the next work item: a read index presents an address and selects,
  // a drain slot only keeps enable high.
  task automatic presentNext();
    int t;
    t = work.pop_front();
    if (t >= 0) begin
      expRd   = 1'b1;
      expEn   = 1'b1;
      expAddr = mBase + 8'(t);
      expBank = 3'(t / 2);
      expSel  = 3'(t % 2);
    end else begin
      expRd = 1'b0;
      expEn = 1'b1;
    end
  endtask

  task automatic modelStep(input logic r, input logic s, input logic [7:0] b, input logic h);
    if (r) begin
      phase   = 0;
      work.delete();
      expRd   = 1'b0;
      expEn   = 1'b0;
      expBusy = 1'b0;
      expDone = 1'b0;
      expAddr = '0;
      expBank = '0;
      expSel  = '0;
    end else if (phase == 0) begin
      expRd   = 1'b0;
      expEn   = 1'b0;
      expDone = 1'b0;
      if (s) begin
        mBase = b;
        work.delete();
        for (int i = 0; i < 16; i++) work.push_back(i);
        for (int i = 0; i < 3; i++) work.push_back(-1);
        presentNext();
        expBusy = 1'b1;
        phase   = 1;
      end
    end else if (phase == 1) begin
      if (h) begin
        expRd = 1'b0;
        expEn = 1'b0;
      end else if (work.size() == 0) begin
        expRd   = 1'b0;
        expEn   = 1'b0;
        expBusy = 1'b0;
        expDone = 1'b1;
        phase   = 2;
      end else begin
        presentNext();
      end
    end else begin
      expDone = 1'b0;
      phase   = 0;
    end
  endtask

  // Check the current cycle, drive this cycle's inputs, advance one edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [7:0] b, input logic h);
    compareAll();
    reset         = r;
    bus.start     = s;
    bus.base_addr = b;
    bus.hold      = h;
    modelStep(r, s, b, h);
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 carries the start. Extra starts use the inverted base so a wrong
  // relatch would be visible on ram_addr.
  task automatic runScenario(input string name, input logic [7:0] base,
                             input int holdS, input int holdL,
                             input int extra1, input int extra2,
                             input int resetAt, input int restartAt,
                             input int expDoneAt);
    int doneAt;
    int doneCnt;
    doneAt  = -1;
    doneCnt = 0;
    for (int c = 0; c < 40; c++) begin
      logic s, h, r;
      logic [7:0] b;
      s = (c == 0) || (c == extra1) || (c == extra2) || (c == restartAt);
      h = (c >= holdS) && (c < holdS + holdL);
      r = (c == resetAt);
      b = ((c == 0) || (c == restartAt)) ? base : ~base;
      applyStimulus(r, s, b, h);
      if (bus.done === 1'b1) begin
        doneCnt++;
        doneAt = c + 1;
      end
    end
    checkOutput({name, "_doneAt"}, 32'(doneAt), 32'(expDoneAt));
    checkOutput({name, "_doneCount"}, 32'(doneCnt), 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.hold      = 1'b0;
    modelStep(1'b1, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

    runScenario("basic",      8'h20, -1, 0, -1, -1, -1, -1, 20);
    runScenario("wrap",       8'hF8, -1, 0, -1, -1, -1, -1, 20);
    runScenario("holdLoad",   8'h40,  5, 3, -1, -1, -1, -1, 23);
    runScenario("holdDrain",  8'h60, 18, 2, -1, -1, -1, -1, 22);
    runScenario("ignoredStart", 8'h20, -1, 0, 5, 20, -1, -1, 20);
    runScenario("resetMid",   8'h80, -1, 0, -1, -1, 10, 12, 32);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom % 100) == 0, ($urandom % 6) == 0,
                    8'($urandom), ($urandom % 4) == 0);
    end
    compareAll();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
